adc_sample_ascii_streamer: RTL and testbench
============================================

Name: adc_sample_ascii_streamer

Overview:
Sits between the ADC receiver and the UART transmitter. It captures each 12-bit ADC sample on the receiver's data-valid strobe and renders it as ASCII hex, three characters MSB-nibble first, optionally followed by CR LF. It then feeds the characters one at a time into the UART transmitter using that transmitter's valid / good-to-reset / send-complete handshake. A one-deep holding buffer decouples sample arrival from the slower serial drain; overruns are counted.

Parameters:
SEND_CRLF, 1, 1 = append 0x0D then 0x0A after the hex digits; 0 = hex digits only
UPPERCASE, 1, 1 = digits A-F map to 0x41-0x46; 0 = 0x61-0x66

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_adc_dv  input  1  one-cycle strobe: i_adc_data is valid
i_adc_data  input  12  ADC sample
o_byte_to_send  output  8  ASCII character to the UART transmitter
o_data_valid  output  1  character valid, to the UART transmitter
i_good_to_reset_dv  input  1  UART has latched the byte; drop valid
i_send_complete  input  1  UART stop bit finished; one-cycle pulse
o_busy  output  1  high while any character of a frame is outstanding
o_overrun_cnt  output  8  saturating count of samples overwritten in the buffer

Behaviour:
- Reset (async assert, sync release): o_byte_to_send=0, o_data_valid=0, o_busy=0, o_overrun_cnt=0, buffer empty, FSM=IDLE, char index=0.
- Buffer: one 12-bit register plus a full flag. i_adc_dv writes the buffer and sets full.
  - If full is already set and the buffer is not being consumed in the same cycle, the new sample overwrites the old one and o_overrun_cnt increments, saturating at 255.
  - If i_adc_dv coincides with the FSM consuming the buffer, the new sample is written, full stays set, and no overrun is counted.
- Frame length N = 5 if SEND_CRLF, else 3. Character k:
  - k=0: nibble [11:8]; k=1: nibble [7:4]; k=2: nibble [3:0].
  - k=3: 0x0D; k=4: 0x0A.
  - Nibble 0-9 maps to 0x30+n. Nibble 10-15 maps to 0x41+(n-10), or 0x61+(n-10) when UPPERCASE=0.
- FSM:
  - IDLE: if full, copy the buffer into a frame register, clear full, set k=0, go to LOAD. o_busy=0 only in IDLE with the buffer empty.
  - LOAD: drive o_byte_to_send=char(k), set o_data_valid=1, go to HANDSHAKE. Latency: the first character is valid 2 cycles after i_adc_dv when starting from IDLE.
  - HANDSHAKE: hold o_data_valid and o_byte_to_send stable. On i_good_to_reset_dv=1, clear o_data_valid on the next edge and go to WAIT_DONE.
  - WAIT_DONE: wait for i_send_complete. Then, if k==N-1, return to IDLE; else k++ and go to LOAD.
- Simultaneous handshake inputs: if i_good_to_reset_dv and i_send_complete are high in the same HANDSHAKE cycle, treat both as taken and advance directly as WAIT_DONE would.
- Out-of-state pulses: i_send_complete in IDLE or LOAD is ignored.
- Frame register: never changes mid-frame. A new sample arriving mid-frame only affects the buffer.
- Back-to-back frames: from IDLE with full set, the next frame starts immediately with no gap cycle beyond IDLE itself.
- Reset mid-frame: all state is cleared immediately and o_data_valid drops asynchronously. The partially sent frame is abandoned and not resumed.

Test Plan:
- Single sample 0xAB3, SEND_CRLF=1, UART model asserting good_to_reset 3 cycles and send_complete 20 cycles after valid -> bytes 0x41,0x42,0x33,0x0D,0x0A in order; o_busy falls 1 cycle after the fifth send_complete.
- UPPERCASE=0, SEND_CRLF=0, sample 0xF0E -> bytes 0x66,0x30,0x65 only; first o_data_valid 2 cycles after i_adc_dv.
- Three samples 0x001, 0x002, 0x003 during one frame -> first frame unaffected; o_overrun_cnt=1; next frame sends 0x003 (0x30,0x30,0x33,...).
- 300 overwriting samples while the UART is stalled (no good_to_reset) -> o_overrun_cnt saturates at 255; o_data_valid and o_byte_to_send stay stable throughout the stall.
- i_good_to_reset_dv and i_send_complete asserted together -> character index advances exactly once and no byte is skipped or repeated.
- i_rst_n pulled low while character k=2 is in HANDSHAKE -> o_data_valid=0 in the same cycle, o_overrun_cnt=0; after release with no new i_adc_dv, no bytes are emitted.

Source files
------------

// File: rtl/adc_sample_ascii_streamer.sv
// Captures 12-bit ADC samples into a one-deep buffer, renders each as three ASCII hex
// characters (optionally followed by CR LF) and hands them one at a time to a UART transmitter.
`timescale 1ns/1ps

module adc_sample_ascii_streamer #(
    parameter bit SEND_CRLF = 1'b1,
    parameter bit UPPERCASE = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_adc_dv,
    input  logic [11:0] i_adc_data,
    output logic [7:0]  o_byte_to_send,
    output logic        o_data_valid,
    input  logic        i_good_to_reset_dv,
    input  logic        i_send_complete,
    output logic        o_busy,
    output logic [7:0]  o_overrun_cnt
);

    localparam logic [2:0] LAST_K = SEND_CRLF ? 3'd4 : 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HANDSHAKE,
        WAIT_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] buf_q, buf_d;
    logic        full_q, full_d;
    logic [11:0] frame_q, frame_d;
    logic [2:0]  k_q, k_d;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic [7:0]  ovr_q, ovr_d;
    logic        consume;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    endfunction

    function automatic logic [7:0] frame_char(input logic [11:0] frame, input logic [2:0] k);
        case (k)
            3'd0:    return hex_char(frame[11:8]);
            3'd1:    return hex_char(frame[7:4]);
            3'd2:    return hex_char(frame[3:0]);
            3'd3:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    // The FSM drains the buffer only from IDLE; a sample landing in that same cycle is not an overrun.
    assign consume = (state_q == IDLE) && full_q;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the block infers a latch.
        state_d = state_q;
        buf_d   = buf_q;
        full_d  = full_q;
        frame_d = frame_q;
        k_d     = k_q;
        byte_d  = byte_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (i_adc_dv) begin
            buf_d  = i_adc_data;
            full_d = 1'b1;
            if (full_q && !consume && (ovr_q != 8'hFF)) begin
                ovr_d = ovr_q + 8'd1;
            end
        end else if (consume) begin
            full_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (full_q) begin
                    frame_d = buf_q;
                    k_d     = 3'd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                byte_d  = frame_char(frame_q, k_q);
                valid_d = 1'b1;
                state_d = HANDSHAKE;
            end
            HANDSHAKE: begin
                if (i_good_to_reset_dv) begin
                    valid_d = 1'b0;
                    if (i_send_complete) begin
                        if (k_q == LAST_K) begin
                            state_d = IDLE;
                        end else begin
                            k_d     = k_q + 3'd1;
                            state_d = LOAD;
                        end
                    end else begin
                        state_d = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (i_send_complete) begin
                    if (k_q == LAST_K) begin
                        state_d = IDLE;
                    end else begin
                        k_d     = k_q + 3'd1;
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            full_q  <= 1'b0;
            frame_q <= '0;
            k_q     <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            frame_q <= frame_d;
            k_q     <= k_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_byte_to_send = byte_q;
    assign o_data_valid   = valid_q;
    assign o_overrun_cnt  = ovr_q;
    assign o_busy         = !((state_q == IDLE) && !full_q);

endmodule

// File: tb/tb_adc_sample_ascii_streamer.sv
// Directed bench for adc_sample_ascii_streamer: a default instance (uppercase, CR LF) and a
// lowercase hex-only instance, each driven through a simple UART handshake model.
`timescale 1ns/1ps

module tb_adc_sample_ascii_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        dv1, gtr1, sc1;
    logic [11:0] data1;
    logic [7:0]  byte1, ovr1;
    logic        v1, busy1;
    logic        dv2, gtr2, sc2;
    logic [11:0] data2;
    logic [7:0]  byte2, ovr2;
    logic        v2, busy2;

    int passes = 0;
    int checks = 0;

    adc_sample_ascii_streamer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_adc_dv(dv1), .i_adc_data(data1),
        .o_byte_to_send(byte1), .o_data_valid(v1), .i_good_to_reset_dv(gtr1),
        .i_send_complete(sc1), .o_busy(busy1), .o_overrun_cnt(ovr1)
    );

    adc_sample_ascii_streamer #(.SEND_CRLF(1'b0), .UPPERCASE(1'b0)) dut_lc (
        .i_clk(clk), .i_rst_n(rst_n), .i_adc_dv(dv2), .i_adc_data(data2),
        .o_byte_to_send(byte2), .o_data_valid(v2), .i_good_to_reset_dv(gtr2),
        .i_send_complete(sc2), .o_busy(busy2), .o_overrun_cnt(ovr2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cur_v(input bit d2);
        return d2 ? v2 : v1;
    endfunction

    function automatic logic [7:0] cur_b(input bit d2);
        return d2 ? byte2 : byte1;
    endfunction

    function automatic logic cur_busy(input bit d2);
        return d2 ? busy2 : busy1;
    endfunction

    task automatic set_hs(input bit d2, input logic g, input logic s);
        if (d2) begin
            gtr2 = g;
            sc2  = s;
        end else begin
            gtr1 = g;
            sc1  = s;
        end
    endtask

    task automatic sample(input bit d2, input logic [11:0] val);
        if (d2) begin
            dv2 = 1'b1; data2 = val;
        end else begin
            dv1 = 1'b1; data1 = val;
        end
        tick();
        dv1 = 1'b0;
        dv2 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_valid(input bit d2, input string tag);
        int n = 0;
        while ((cur_v(d2) !== 1'b1) && (n < 200)) begin
            tick();
            n++;
        end
        chk({tag, " valid"}, {31'd0, cur_v(d2)}, 32'd1);
    endtask

    // UART model: good_to_reset 3 cycles after valid, send_complete 20 cycles after valid,
    // or both together one cycle after valid when 'both' is set.
    task automatic serve(input bit d2, input logic [7:0] exp, input string tag, input bit both);
        wait_valid(d2, tag);
        chk({tag, " byte"}, {24'd0, cur_b(d2)}, {24'd0, exp});
        if (both) begin
            set_hs(d2, 1'b1, 1'b1);
            tick();
            set_hs(d2, 1'b0, 1'b0);
            chk({tag, " drop"}, {31'd0, cur_v(d2)}, 32'd0);
        end else begin
            tick();
            tick();
            chk({tag, " hold"}, {23'd0, cur_v(d2), cur_b(d2)}, {23'd0, 1'b1, exp});
            set_hs(d2, 1'b1, 1'b0);
            tick();
            set_hs(d2, 1'b0, 1'b0);
            chk({tag, " drop"}, {31'd0, cur_v(d2)}, 32'd0);
            repeat (16) tick();
            chk({tag, " busy"}, {31'd0, cur_busy(d2)}, 32'd1);
            set_hs(d2, 1'b0, 1'b1);
            tick();
            set_hs(d2, 1'b0, 1'b0);
        end
    endtask

    task automatic quiet(input bit d2, input int cycles, input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (cur_v(d2) !== 1'b0) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        logic stable;
        rst_n = 1'b0;
        dv1 = 1'b0; gtr1 = 1'b0; sc1 = 1'b0; data1 = '0;
        dv2 = 1'b0; gtr2 = 1'b0; sc2 = 1'b0; data2 = '0;
        tick();
        tick();
        chk("rst byte", {24'd0, byte1}, 32'h00);
        chk("rst valid", {31'd0, v1}, 32'd0);
        chk("rst busy", {31'd0, busy1}, 32'd0);
        chk("rst ovr", {24'd0, ovr1}, 32'd0);
        chk("rst lc valid", {31'd0, v2}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Lowercase, no CR LF: 0xF0E -> "f0e"; valid two edges after the capture edge.
        sample(1'b1, 12'hF0E);
        chk("lat0", {31'd0, v2}, 32'd0);
        tick();
        chk("lat1", {31'd0, v2}, 32'd0);
        tick();
        chk("lat2", {31'd0, v2}, 32'd1);
        serve(1'b1, 8'h66, "lc0", 1'b0);
        serve(1'b1, 8'h30, "lc1", 1'b0);
        serve(1'b1, 8'h65, "lc2", 1'b0);
        chk("lc busy end", {31'd0, busy2}, 32'd0);
        quiet(1'b1, 30, "lc no extra");

        // 0xAB3 with CR LF; busy drops on the edge that takes the fifth send_complete.
        sample(1'b0, 12'hAB3);
        serve(1'b0, 8'h41, "ab0", 1'b0);
        serve(1'b0, 8'h42, "ab1", 1'b0);
        serve(1'b0, 8'h33, "ab2", 1'b0);
        serve(1'b0, 8'h0D, "ab3", 1'b0);
        serve(1'b0, 8'h0A, "ab4", 1'b0);
        chk("ab busy end", {31'd0, busy1}, 32'd0);

        // 0x001 starts a frame, 0x002 fills the buffer, 0x003 overwrites it.
        do_reset();
        sample(1'b0, 12'h001);
        tick();
        sample(1'b0, 12'h002);
        sample(1'b0, 12'h003);
        chk("ov cnt", {24'd0, ovr1}, 32'd1);
        serve(1'b0, 8'h30, "ov0", 1'b0);
        serve(1'b0, 8'h30, "ov1", 1'b0);
        serve(1'b0, 8'h31, "ov2", 1'b0);
        serve(1'b0, 8'h0D, "ov3", 1'b0);
        serve(1'b0, 8'h0A, "ov4", 1'b0);
        chk("ov busy pending", {31'd0, busy1}, 32'd1);
        serve(1'b0, 8'h30, "nx0", 1'b0);
        serve(1'b0, 8'h30, "nx1", 1'b0);
        serve(1'b0, 8'h33, "nx2", 1'b0);
        serve(1'b0, 8'h0D, "nx3", 1'b0);
        serve(1'b0, 8'h0A, "nx4", 1'b0);
        chk("nx busy end", {31'd0, busy1}, 32'd0);
        chk("nx ovr kept", {24'd0, ovr1}, 32'd1);

        // 300 samples while the UART stalls: first fills, 299 overwrite, count saturates.
        do_reset();
        sample(1'b0, 12'h123);
        wait_valid(1'b0, "st first");
        stable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            dv1 = 1'b1;
            data1 = 12'(i);
            tick();
            if ((v1 !== 1'b1) || (byte1 !== 8'h31)) stable = 1'b0;
        end
        dv1 = 1'b0;
        chk("st stable", {31'd0, stable}, 32'd1);
        chk("st sat", {24'd0, ovr1}, 32'd255);
        serve(1'b0, 8'h31, "st0", 1'b0);
        serve(1'b0, 8'h32, "st1", 1'b0);
        serve(1'b0, 8'h33, "st2", 1'b0);
        serve(1'b0, 8'h0D, "st3", 1'b0);
        serve(1'b0, 8'h0A, "st4", 1'b0);
        serve(1'b0, 8'h31, "sl0", 1'b0);
        serve(1'b0, 8'h32, "sl1", 1'b0);
        serve(1'b0, 8'h42, "sl2", 1'b0);
        serve(1'b0, 8'h0D, "sl3", 1'b0);
        serve(1'b0, 8'h0A, "sl4", 1'b0);
        chk("sl busy end", {31'd0, busy1}, 32'd0);

        // good_to_reset and send_complete together each character.
        do_reset();
        sample(1'b0, 12'h5C7);
        serve(1'b0, 8'h35, "bo0", 1'b1);
        serve(1'b0, 8'h43, "bo1", 1'b1);
        serve(1'b0, 8'h37, "bo2", 1'b1);
        serve(1'b0, 8'h0D, "bo3", 1'b1);
        serve(1'b0, 8'h0A, "bo4", 1'b1);
        chk("bo busy end", {31'd0, busy1}, 32'd0);
        quiet(1'b0, 20, "bo no extra");

        // Reset asserted mid-cycle while character 2 is in HANDSHAKE.
        do_reset();
        sample(1'b0, 12'h9A1);
        serve(1'b0, 8'h39, "rs0", 1'b0);
        serve(1'b0, 8'h41, "rs1", 1'b0);
        wait_valid(1'b0, "rs2");
        chk("rs2 byte", {24'd0, byte1}, 32'h31);
        sample(1'b0, 12'h111);
        sample(1'b0, 12'h222);
        chk("rs ovr pre", {24'd0, ovr1}, 32'd1);
        chk("rs valid pre", {31'd0, v1}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs async valid", {31'd0, v1}, 32'd0);
        chk("rs async ovr", {24'd0, ovr1}, 32'd0);
        chk("rs async busy", {31'd0, busy1}, 32'd0);
        tick();
        rst_n = 1'b1;
        quiet(1'b0, 40, "rs no resume");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
